// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Sits behind the FFT core. On a rising edge of fft_done it reads every
//   positive-frequency bin back from the core's result RAM, computes
//   |re| + |im| for each one and keeps the largest. When the sweep is over it
//   reports the winning bin and its magnitude with a one-cycle pulse.
//
//   Optional feature macro: PEAK_THRESH_EN
//     When defined, a magnitude threshold input is added. A peak below the
//     threshold is reported as bin 0 / mag 0 with peak_found low.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   fft_done    in   FFT core results valid; a rising edge starts a sweep
//   dout        in   FFT result {real, imag}, each BIT_WIDTH signed
//   mag_thresh  in   (PEAK_THRESH_EN) minimum magnitude counted as a peak
//   add_rd      out  bin read address to the FFT core
//   busy        out  high while sweeping, draining or reporting
//   peak_valid  out  one-cycle pulse when peak_bin/peak_mag are updated
//   peak_bin    out  index of the largest-magnitude bin
//   peak_mag    out  |re| + |im| of that bin, unsigned
//   peak_found  out  (PEAK_THRESH_EN) peak met the threshold

module fft_peak_detect #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int RD_LAT    = 1,
    parameter int SKIP_DC   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] dout,
`ifdef PEAK_THRESH_EN
    input  logic [BIT_WIDTH:0]     mag_thresh,
    output logic                   peak_found,
`endif
    output logic [N-1:0]           add_rd,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [N-2:0]           peak_bin,
    output logic [BIT_WIDTH:0]     peak_mag
);

    localparam logic [N-1:0] FIRST_ADDR = N'(SKIP_DC);
    localparam logic [N-1:0] LAST_ADDR  = N'((1 << (N - 1)) - 1);
    localparam logic [N-2:0] FIRST_BIN  = (N - 1)'(SKIP_DC);
    // DRAIN covers the RAM read latency plus the two datapath stages.
    localparam int           DRAIN_W    = $clog2(RD_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic               done_q;
    logic               done_rise;
    logic               start;
    logic               load;
    logic [DRAIN_W-1:0] drain_cnt;

    // Bin tag / valid shift register lining each address up with its dout
    logic [N-2:0]       tag_d [RD_LAT];
    logic [RD_LAT-1:0]  vld_d;

    logic signed [BIT_WIDTH-1:0] re_in;
    logic signed [BIT_WIDTH-1:0] im_in;

    logic [BIT_WIDTH-1:0] re_abs_p1;
    logic [BIT_WIDTH-1:0] im_abs_p1;
    logic [N-2:0]         bin_p1;
    logic                 vld_p1;

    logic [BIT_WIDTH:0]   mag_p2;
    logic [N-2:0]         bin_p2;
    logic                 vld_p2;

    logic [BIT_WIDTH:0]   max_mag;
    logic [N-2:0]         max_bin;
    logic                 upd;
    logic [BIT_WIDTH:0]   best_mag;
    logic [N-2:0]         best_bin;

    // Two's complement magnitude; the most negative value maps to 2^(BW-1),
    // which still fits in BW unsigned bits, so no saturation is needed.
    function automatic logic [BIT_WIDTH-1:0] abs_u(input logic signed [BIT_WIDTH-1:0] x);
        logic [BIT_WIDTH-1:0] u;
        u = x;
        return x[BIT_WIDTH-1] ? (~u + BIT_WIDTH'(1)) : u;
    endfunction

    assign re_in     = dout[2*BIT_WIDTH-1:BIT_WIDTH];
    assign im_in     = dout[BIT_WIDTH-1:0];
    assign done_rise = fft_done & ~done_q;

    // Strictly greater keeps the lowest bin on ties. The best-of view lets the
    // report capture the final bin in the same edge it leaves stage 2.
    assign upd      = vld_p2 && (mag_p2 > max_mag);
    assign best_mag = upd ? mag_p2 : max_mag;
    assign best_bin = upd ? bin_p2 : max_bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        peak_valid = 1'b0;
        start      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (done_rise) begin
                    state_nxt = SWEEP;
                    start     = 1'b1;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (add_rd == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = REPORT;
                    load      = 1'b1;
                end
            end
            REPORT: begin
                busy       = 1'b1;
                peak_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q     <= 1'b0;
            add_rd     <= '0;
            drain_cnt  <= '0;
            vld_d      <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            max_mag    <= '0;
            max_bin    <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
`ifdef PEAK_THRESH_EN
            peak_found <= 1'b0;
`endif
        end else begin
            done_q <= fft_done;

            case (state)
                IDLE:    add_rd <= start ? FIRST_ADDR : '0;
                SWEEP:   if (add_rd != LAST_ADDR) add_rd <= add_rd + N'(1);
                REPORT:  add_rd <= '0;
                default: add_rd <= add_rd;
            endcase

            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;

            vld_d[0] <= (state == SWEEP);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_d[i] <= vld_d[i-1];
            end
            vld_p1 <= vld_d[RD_LAT-1];
            vld_p2 <= vld_p1;

            if (start) begin
                max_mag <= '0;
                max_bin <= FIRST_BIN;
            end else if (upd) begin
                max_mag <= mag_p2;
                max_bin <= bin_p2;
            end

            if (load) begin
`ifdef PEAK_THRESH_EN
                if (best_mag >= mag_thresh) begin
                    peak_found <= 1'b1;
                    peak_bin   <= best_bin;
                    peak_mag   <= best_mag;
                end else begin
                    peak_found <= 1'b0;
                    peak_bin   <= '0;
                    peak_mag   <= '0;
                end
`else
                peak_bin <= best_bin;
                peak_mag <= best_mag;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_d[0] <= add_rd[N-2:0];
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] <= tag_d[i-1];
        end

        // ---- stage 1: component magnitudes ----
        re_abs_p1 <= abs_u(re_in);
        im_abs_p1 <= abs_u(im_in);
        bin_p1    <= tag_d[RD_LAT-1];

        // ---- stage 2: L1 magnitude ----
        mag_p2 <= {1'b0, re_abs_p1} + {1'b0, im_abs_p1};
        bin_p2 <= bin_p1;
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

    localparam int BW      = 16;
    localparam int N       = 9;
    localparam int RD_LAT  = 1;
    localparam int SKIP_DC = 1;
    localparam int HALF    = 1 << (N - 1);
    localparam int M       = HALF - SKIP_DC;
    localparam int LAT     = M + RD_LAT + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              fft_done;
    logic [2*BW-1:0]   dout;
    logic [N-1:0]      add_rd;
    logic              busy;
    logic              peak_valid;
    logic [N-2:0]      peak_bin;
    logic [BW:0]       peak_mag;
`ifdef PEAK_THRESH_EN
    logic [BW:0]       mag_thresh;
    logic              peak_found;
`endif

    int thr = 0;

    fft_peak_detect #(
        .BIT_WIDTH(BW), .N(N), .RD_LAT(RD_LAT), .SKIP_DC(SKIP_DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_done   (fft_done),
        .dout       (dout),
`ifdef PEAK_THRESH_EN
        .mag_thresh (mag_thresh),
        .peak_found (peak_found),
`endif
        .add_rd     (add_rd),
        .busy       (busy),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag)
    );

`ifdef PEAK_THRESH_EN
    assign mag_thresh = (BW + 1)'(thr);
`endif

    always #5 clk = ~clk;

    typedef struct {
        int     bin;
        int     mag;
        bit     found;
        longint cyc;
    } exp_t;

    exp_t             sbq[$];
    logic signed [BW-1:0] mem_re [1 << N];
    logic signed [BW-1:0] mem_im [1 << N];
    longint           cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    int               n_push = 0;
    int               n_report = 0;
    int               hits [1 << N];
    logic [N-1:0]     prev_addr = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM read, one cycle of latency
    initial forever begin
        @(posedge clk);
        dout <= {mem_re[add_rd], mem_im[add_rd]};
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: scan the positive half, largest |re|+|im|, earliest bin wins ties
    function automatic exp_t model(input int th);
        exp_t e;
        int r, i, m;
        e.bin = SKIP_DC;
        e.mag = 0;
        for (int b = SKIP_DC; b < HALF; b++) begin
            r = mem_re[b];
            i = mem_im[b];
            m = (r < 0 ? -r : r) + (i < 0 ? -i : i);
            if (m > e.mag) begin
                e.mag = m;
                e.bin = b;
            end
        end
        e.found = (e.mag >= th);
        if (!e.found) begin
            e.bin = 0;
            e.mag = 0;
        end
        e.cyc = 0;
        return e;
    endfunction

    task automatic clear_mem();
        for (int b = 0; b < (1 << N); b++) begin
            mem_re[b] = '0;
            mem_im[b] = '0;
        end
    endtask

    task automatic sweep(input int hold);
        exp_t e;
        @(negedge clk);
`ifdef PEAK_THRESH_EN
        e = model(thr);
`else
        e = model(0);
`endif
        e.cyc = cyc + LAT + 1;
        sbq.push_back(e);
        n_push++;
        fft_done = 1'b1;
        repeat (hold) @(negedge clk);
        fft_done = 1'b0;
    endtask

    task automatic wait_report();
        int t = 0;
        while (sbq.size() != 0 && t < 2 * LAT) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            check("report_timeout", 0, 1);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: address coverage and report scoreboard
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            for (int b = 0; b < (1 << N); b++) hits[b] = 0;
            prev_addr = '0;
        end else begin
            if (busy && add_rd != prev_addr) hits[add_rd]++;
            prev_addr = add_rd;
            if (peak_valid) begin
                n_report++;
                if (sbq.size() == 0) begin
                    check("unexpected_peak_valid", 1, 0);
                end else begin
                    exp_t e;
                    int ok;
                    e = sbq.pop_front();
                    check("peak_bin", longint'(peak_bin), e.bin);
                    check("peak_mag", longint'(peak_mag), e.mag);
                    check("latency_cycle", cyc, e.cyc);
`ifdef PEAK_THRESH_EN
                    check("peak_found", longint'(peak_found), longint'(e.found));
`endif
                    ok = 0;
                    for (int b = 0; b < (1 << N); b++) begin
                        if (hits[b] == ((b >= SKIP_DC && b < HALF) ? 1 : 0)) ok++;
                    end
                    check("addr_sweep_once", ok, 1 << N);
                end
                for (int b = 0; b < (1 << N); b++) hits[b] = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        fft_done = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_add_rd", longint'(add_rd), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_peak_valid", longint'(peak_valid), 0);
        check("rst_peak_bin", longint'(peak_bin), 0);
        check("rst_peak_mag", longint'(peak_mag), 0);
`ifdef PEAK_THRESH_EN
        check("rst_peak_found", longint'(peak_found), 0);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single bin
        mem_re[37] = 16'sd1000;
        mem_im[37] = -16'sd500;
        sweep(3);
        wait_report();

        // Tie: lowest bin wins
        clear_mem();
        mem_re[10] = 16'sd300; mem_im[10] = 16'sd300;
        mem_re[20] = 16'sd300; mem_im[20] = 16'sd300;
        sweep(1);
        wait_report();

        // Full-scale negative, DC bin ignored
        clear_mem();
        mem_re[200] = -16'sd32768; mem_im[200] = -16'sd32768;
        mem_re[0]   = 16'sd32767;
        sweep(2);
        wait_report();

        // All zero, then fft_done held high: exactly one report
        clear_mem();
        sweep(2);
        wait_report();
        mem_re[5] = 16'sd7;
        sweep(600);
        wait_report();
        check("held_high_reports", n_report, n_push);

        // Asynchronous reset in the middle of a sweep
        clear_mem();
        mem_re[37] = 16'sd1000; mem_im[37] = -16'sd500;
        @(negedge clk);
        fft_done = 1'b1;
        repeat (2) @(negedge clk);
        fft_done = 1'b0;
        repeat (98) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_add_rd", longint'(add_rd), 0);
        check("async_rst_busy", longint'(busy), 0);
        check("async_rst_peak_valid", longint'(peak_valid), 0);
        check("async_rst_peak_bin", longint'(peak_bin), 0);
        check("async_rst_peak_mag", longint'(peak_mag), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_report", n_report, n_push);
        sweep(3);
        wait_report();

`ifdef PEAK_THRESH_EN
        thr = 2000;
        sweep(3);
        wait_report();
        thr = 1500;
        sweep(3);
        wait_report();
`endif

        // Randomized spectra, some with many small values to force ties
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < (1 << N); b++) begin
                if (k % 2 == 0) begin
                    mem_re[b] = BW'($urandom);
                    mem_im[b] = BW'($urandom);
                end else begin
                    mem_re[b] = BW'(int'($urandom_range(0, 6)) - 3);
                    mem_im[b] = BW'(int'($urandom_range(0, 6)) - 3);
                end
            end
            if (k == 2) mem_re[$urandom_range(1, HALF - 1)] = -16'sd32768;
`ifdef PEAK_THRESH_EN
            thr = (k % 2 == 0) ? int'($urandom_range(0, 65536)) : int'($urandom_range(0, 8));
`endif
            sweep(1 + int'($urandom_range(0, 4)));
            wait_report();
        end

        check("scoreboard_empty", sbq.size(), 0);
        check("report_count", n_report, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
